jtkcpu_pshpul: RTL and testbench
================================

// Module: jtkcpu_pshpul
// PURPOSE
// - Sequencer for PSHS/PSHU/PULS/PULU, and for interrupt stacking, driving the CPU register file.
// - Walks the postbyte mask one register at a time and drives psh_sel (one-hot), psh_hilon, pshdec and pul_en.
// - Issues the matching byte memory strobes. The address comes from the register file's psh_addr.
// - Sits between the instruction-control FSM and the register file; the control FSM stalls while busy=1.
// PARAMETERS
// - RDWAIT  default 0  extra cen cycles between mem_rd and pul_en, to cover memory read latency (0..3).
// PORTS
// - rst        in   1  synchronous, active-high reset
// - clk        in   1  single clock; all state updates on posedge clk
// - cen        in   1  clock enable; state advances only when cen=1
// - start_psh  in   1  one-cycle request: push registers selected by mask
// - start_pul  in   1  one-cycle request: pull registers selected by mask
// - mask       in   8  postbyte; b0 CC, b1 A, b2 B, b3 DP, b4 X, b5 Y, b6 U/S, b7 PC
// - psh_sel    out  8  one-hot current register, to the register file (0 when idle)
// - psh_hilon  out  1  1 = high byte of a 16-bit register is being moved
// - pshdec     out  1  pre-decrement the stack pointer (push)
// - pul_en     out  1  latch read byte and post-increment the stack pointer (pull)
// - mem_wr     out  1  write psh_mux to memory at psh_addr
// - mem_rd     out  1  read memory at psh_addr
// - busy       out  1  a sequence is in progress
// - done       out  1  one-cen-cycle pulse once the sequence is complete
// BEHAVIOUR
// - Reset: state=IDLE, pending mask=0, wait counter=0, all outputs 0. Reset mid-sequence aborts at once.
// - Outputs are Moore decodes of the state; with cen=0 they hold and nothing advances.
// - IDLE: start_psh wins over start_pul when both are high. A zero mask goes straight to DONE (no memory access).
//   - Otherwise latch mask into pend and go to PDEC (push) or PRD (pull). Starts are ignored when busy=1.
// - Push order is highest set bit first (PC ... CC).
//   - Each byte takes two cycles: PDEC (pshdec=1), then PWR (mem_wr=1).
//   - For a 16-bit register (b4..b7) the low byte goes first (hilon=0), then the high byte (hilon=1).
//   - This leaves the high byte at the lower address.
// - Pull order is lowest set bit first (CC ... PC).
//   - Each byte: PRD (mem_rd=1), then RDWAIT cycles in PWT (mem_rd held), then PLD (pul_en=1).
//   - For a 16-bit register the high byte goes first (hilon=1), then the low byte.
// - After the last byte of a register, clear its bit in pend. If pend is then 0, go to DONE; otherwise start the next register.
// - DONE: done=1 and busy=1 for one cen cycle, then IDLE.
// - busy=1 in every state except IDLE.
// - Cycle count (RDWAIT=0): 2 per 8-bit register, 4 per 16-bit register, plus 1 for DONE.
//   - Full mask 0xFF takes 25 cen cycles after start.
// - psh_sel always has exactly one bit set while in PDEC, PWR, PRD, PWT or PLD; it is 0 otherwise.
// - pshdec, pul_en, mem_wr and mem_rd are mutually exclusive.
// - The U/S choice (psh_ussel) is held by the control FSM. This block does not drive it.
// STRUCTURE
// - jtkcpu_pkg holds: state encodings (IDLE, PDEC, PWR, PRD, PWT, PLD, DONE); mask bit constants PSH_CC..PSH_PC.
// - Sub-module jtkcpu_bitpick is combinational. Given pend and the direction, it returns one-hot highest or lowest set bit, plus an is16 flag (bit >= 4).
// - Byte phase: one flag (hilon). Wait counter: 2 bits.
// TESTING
// - Push mask 0x81, cen=1. Expected sequence, 7 cycles:
//   PDEC, PWR (psh_sel=0x80, hilon=0), PDEC, PWR (0x80, hilon=1), PDEC, PWR (0x01), done.
// - Pull mask 0x06 -> PRD, PLD with psh_sel=0x02, then PRD, PLD with 0x04; done in cycle 5; mem_rd count = 2.
// - Pull mask 0x10 with RDWAIT=2 -> hi byte: PRD, PWT, PWT, PLD (hilon=1); then lo byte, same; done on cycle 9.
// - Mask 0x00 with start_pul -> done one cycle later; no mem_rd, mem_wr, pshdec or pul_en.
// - start_psh and start_pul both high, mask 0x02 -> push executes (one pshdec, one mem_wr). A start during busy is ignored.
// - cen toggled 1010.. during push 0xFF -> same strobe sequence, stretched 2x.
//   Reset asserted mid-push -> next cycle busy=0, psh_sel=0, all strobes 0.

Source files
------------

// File: rtl/jtkcpu_pkg.sv
// Shared definitions for the push/pull sequencer: state encodings and
// postbyte bit positions.
package jtkcpu_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PDEC = 3'd1,
        PWR  = 3'd2,
        PRD  = 3'd3,
        PWT  = 3'd4,
        PLD  = 3'd5,
        DONE = 3'd6
    } pshpul_state_t;

    localparam int PSH_CC = 0;
    localparam int PSH_A  = 1;
    localparam int PSH_B  = 2;
    localparam int PSH_DP = 3;
    localparam int PSH_X  = 4;
    localparam int PSH_Y  = 5;
    localparam int PSH_US = 6;
    localparam int PSH_PC = 7;

    // A pull starts with the lowest set bit; that register is 16-bit
    // only when none of the 8-bit registers remain.
    function automatic logic low_is16(input logic [7:0] p);
        return p[PSH_DP:PSH_CC] == 4'd0;
    endfunction

endpackage

// File: rtl/jtkcpu_bitpick.sv
// Picks the next register from the pending mask: highest set bit for a
// push, lowest for a pull, and flags whether it is a 16-bit register.
module jtkcpu_bitpick
    import jtkcpu_pkg::*;
(
    input  logic [7:0] pend,
    input  logic       lowest,
    output logic [7:0] sel,
    output logic       is16
);

    int idx;

    // Scan order is chosen so that the last hit is the wanted bit
    always_comb begin
        sel = '0;
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            idx = lowest ? 7 - i : i;
            if (pend[idx[2:0]]) begin
                sel = '0;
                sel[idx[2:0]] = 1'b1;
            end
        end
    end

    assign is16 = |sel[PSH_PC:PSH_X];

endmodule

// File: rtl/jtkcpu_pshpul.sv
// Push/pull sequencer: walks the postbyte mask one byte at a time and
// drives the register-file controls and memory strobes.
module jtkcpu_pshpul
    import jtkcpu_pkg::*;
#(
    parameter int RDWAIT = 0
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       cen,
    input  logic       start_psh,
    input  logic       start_pul,
    input  logic [7:0] mask,
    output logic [7:0] psh_sel,
    output logic       psh_hilon,
    output logic       pshdec,
    output logic       pul_en,
    output logic       mem_wr,
    output logic       mem_rd,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] WAIT_INIT = 2'((RDWAIT > 0) ? RDWAIT - 1 : 0);

    pshpul_state_t st, st_nx;
    logic [7:0]    pend, pend_nx, pend_clr;
    logic          hilon, hilon_nx;
    logic [1:0]    wcnt, wcnt_nx;
    logic [7:0]    pick;
    logic          is16, pul_dir, active;

    assign pul_dir  = (st == PRD) || (st == PWT) || (st == PLD);
    assign active   = (st != IDLE) && (st != DONE);
    assign pend_clr = pend & ~pick;

    jtkcpu_bitpick u_pick (
        .pend   (pend),
        .lowest (pul_dir),
        .sel    (pick),
        .is16   (is16)
    );

    always_comb begin
        st_nx    = st;
        pend_nx  = pend;
        hilon_nx = hilon;
        wcnt_nx  = wcnt;
        case (st)
            IDLE: begin
                if (start_psh || start_pul) begin
                    if (mask == 8'd0) begin
                        st_nx = DONE;
                    end else begin
                        pend_nx  = mask;
                        // push sends the low byte first, pull the high byte
                        hilon_nx = start_psh ? 1'b0 : low_is16(mask);
                        st_nx    = start_psh ? PDEC : PRD;
                    end
                end
            end
            PDEC: st_nx = PWR;
            PWR: begin
                if (is16 && !hilon) begin
                    hilon_nx = 1'b1;
                    st_nx    = PDEC;
                end else begin
                    pend_nx  = pend_clr;
                    hilon_nx = 1'b0;
                    st_nx    = (pend_clr == 8'd0) ? DONE : PDEC;
                end
            end
            PRD: begin
                if (RDWAIT == 0) begin
                    st_nx = PLD;
                end else begin
                    wcnt_nx = WAIT_INIT;
                    st_nx   = PWT;
                end
            end
            PWT: begin
                if (wcnt == 2'd0) st_nx = PLD;
                else              wcnt_nx = wcnt - 2'd1;
            end
            PLD: begin
                if (is16 && hilon) begin
                    hilon_nx = 1'b0;
                    st_nx    = PRD;
                end else begin
                    pend_nx  = pend_clr;
                    hilon_nx = low_is16(pend_clr);
                    st_nx    = (pend_clr == 8'd0) ? DONE : PRD;
                end
            end
            DONE:    st_nx = IDLE;
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= IDLE;
            pend  <= '0;
            hilon <= 1'b0;
            wcnt  <= '0;
        end else if (cen) begin
            st    <= st_nx;
            pend  <= pend_nx;
            hilon <= hilon_nx;
            wcnt  <= wcnt_nx;
        end
    end

    assign psh_sel   = active ? pick : 8'd0;
    assign psh_hilon = active & hilon;
    assign pshdec    = (st == PDEC);
    assign mem_wr    = (st == PWR);
    assign mem_rd    = (st == PRD) || (st == PWT);
    assign pul_en    = (st == PLD);
    assign busy      = (st != IDLE);
    assign done      = (st == DONE);

endmodule

// File: tb/tb_jtkcpu_pshpul.sv
// Bench for the push/pull sequencer: two instances (RDWAIT 0 and 2) compared
// every cycle against a per-cycle expected-frame list built from the mask.
module tb_jtkcpu_pshpul;

    typedef struct packed {
        logic [7:0] sel;
        logic       hilon;
        logic       pshdec;
        logic       pul_en;
        logic       mem_wr;
        logic       mem_rd;
        logic       busy;
        logic       done;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst, cen, start_psh, start_pul;
    logic [7:0] mask;

    logic [7:0] o0_sel, o2_sel;
    logic o0_hilon, o0_pshdec, o0_pul_en, o0_mem_wr, o0_mem_rd, o0_busy, o0_done;
    logic o2_hilon, o2_pshdec, o2_pul_en, o2_mem_wr, o2_mem_rd, o2_busy, o2_done;

    frame_t act0, act2, cur0, cur2;
    frame_t q0[$];
    frame_t q2[$];

    int  checks = 0;
    int  passes = 0;
    bit  chk_on = 0;
    int  n0, n2, cnt_rd, cnt_wr, cnt_dec, cnt_pul;

    always #5 clk = ~clk;

    jtkcpu_pshpul #(.RDWAIT(0)) u0 (
        .rst(rst), .clk(clk), .cen(cen), .start_psh(start_psh), .start_pul(start_pul),
        .mask(mask), .psh_sel(o0_sel), .psh_hilon(o0_hilon), .pshdec(o0_pshdec),
        .pul_en(o0_pul_en), .mem_wr(o0_mem_wr), .mem_rd(o0_mem_rd), .busy(o0_busy),
        .done(o0_done)
    );

    jtkcpu_pshpul #(.RDWAIT(2)) u2 (
        .rst(rst), .clk(clk), .cen(cen), .start_psh(start_psh), .start_pul(start_pul),
        .mask(mask), .psh_sel(o2_sel), .psh_hilon(o2_hilon), .pshdec(o2_pshdec),
        .pul_en(o2_pul_en), .mem_wr(o2_mem_wr), .mem_rd(o2_mem_rd), .busy(o2_busy),
        .done(o2_done)
    );

    assign act0 = {o0_sel, o0_hilon, o0_pshdec, o0_pul_en, o0_mem_wr, o0_mem_rd, o0_busy, o0_done};
    assign act2 = {o2_sel, o2_hilon, o2_pshdec, o2_pul_en, o2_mem_wr, o2_mem_rd, o2_busy, o2_done};

    function automatic frame_t mk(input logic [7:0] s, input logic h, input logic dec,
                                  input logic pul, input logic wr, input logic rd,
                                  input logic dn);
        frame_t f;
        f = {s, h, dec, pul, wr, rd, 1'b1, dn};
        return f;
    endfunction

    function automatic void add(input int k, input frame_t f);
        if (k == 0) q0.push_back(f);
        else        q2.push_back(f);
    endfunction

    // Expected per-cen-cycle outputs for one request, straight from the
    // byte ordering rules: push PC..CC lo/hi, pull CC..PC hi/lo.
    function automatic void build(input int k, input bit psh, input logic [7:0] m);
        int rw;
        int nb;
        logic [7:0] s;
        logic h;
        rw = (k == 0) ? 0 : 2;
        if (psh) begin
            for (int i = 7; i >= 0; i--) begin
                if (m[i]) begin
                    s  = 8'(1 << i);
                    nb = (i >= 4) ? 2 : 1;
                    for (int b = 0; b < nb; b++) begin
                        h = (b == 1);
                        add(k, mk(s, h, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
                        add(k, mk(s, h, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
                    end
                end
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (m[i]) begin
                    s  = 8'(1 << i);
                    nb = (i >= 4) ? 2 : 1;
                    for (int b = 0; b < nb; b++) begin
                        h = (i >= 4) && (b == 0);
                        add(k, mk(s, h, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
                        for (int w = 0; w < rw; w++)
                            add(k, mk(s, h, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
                        add(k, mk(s, h, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
                    end
                end
            end
        end
        add(k, mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    endfunction

    // Model advances on the same edges as the DUT
    always @(posedge clk) begin
        if (rst) begin
            q0.delete();
            q2.delete();
            cur0 = '0;
            cur2 = '0;
        end else if (cen) begin
            if (q0.size() > 0) cur0 = q0.pop_front();
            else if (cur0.busy) cur0 = '0;
            else if (start_psh || start_pul) begin
                build(0, start_psh, mask);
                cur0 = q0.pop_front();
            end
            if (q2.size() > 0) cur2 = q2.pop_front();
            else if (cur2.busy) cur2 = '0;
            else if (start_psh || start_pul) begin
                build(2, start_psh, mask);
                cur2 = q2.pop_front();
            end
        end
    end

    task automatic chk_frame(input string nm, input frame_t a, input frame_t e);
        checks++;
        if (a === e) passes++;
        else $display("FAIL %s t=%0t got=%h want=%h", nm, $time, a, e);
    endtask

    task automatic chk_int(input string nm, input int a, input int e);
        checks++;
        if (a == e) passes++;
        else $display("FAIL %s got=%0d want=%0d", nm, a, e);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk_frame("rd0_frame", act0, cur0);
            chk_frame("rd2_frame", act2, cur2);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic note_frame;
        if (n0 == 0) begin
            cnt_rd  += int'(o0_mem_rd);
            cnt_wr  += int'(o0_mem_wr);
            cnt_dec += int'(o0_pshdec);
            cnt_pul += int'(o0_pul_en);
        end
    endtask

    // mode: 0 cen always 1, 1 cen toggling, 2 cen random; exp < 0 skips latency check
    task automatic run(input string nm, input bit ps, input bit pl, input logic [7:0] m,
                       input int mode, input int exp0, input int exp2, input bit spur);
        int k;
        n0 = 0; n2 = 0; cnt_rd = 0; cnt_wr = 0; cnt_dec = 0; cnt_pul = 0;
        cen = 1'b1; start_psh = ps; start_pul = pl; mask = m;
        tick;
        start_psh = 1'b0; start_pul = 1'b0;
        k = 1;
        note_frame();
        if (o0_done) n0 = k;
        if (o2_done) n2 = k;
        for (int it = 0; it < 400 && (n0 == 0 || n2 == 0); it++) begin
            case (mode)
                0:       cen = 1'b1;
                1:       cen = (it % 2 == 1);
                default: cen = ($urandom_range(0, 3) != 0);
            endcase
            if (spur && it == 0) begin
                start_pul = 1'b1;
                mask = 8'hFF;
            end
            tick;
            start_psh = 1'b0; start_pul = 1'b0;
            if (cen) begin
                k++;
                note_frame();
                if (o0_done && n0 == 0) n0 = k;
                if (o2_done && n2 == 0) n2 = k;
            end
        end
        if (exp0 >= 0) chk_int({nm, "_lat_rd0"}, n0, exp0);
        if (exp2 >= 0) chk_int({nm, "_lat_rd2"}, n2, exp2);
        if (exp0 < 0 && (n0 == 0 || n2 == 0)) chk_int({nm, "_timeout"}, 0, 1);
        cen = 1'b1;
        tick;
        tick;
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; start_psh = 1'b0; start_pul = 1'b0; mask = 8'd0;
        tick;
        chk_on = 1'b1;
        tick;
        rst = 1'b0;
        tick;
        chk_frame("reset_rd0", act0, '0);
        chk_frame("reset_rd2", act2, '0);

        run("push81", 1'b1, 1'b0, 8'h81, 0, 7, 7, 1'b0);
        chk_int("push81_wr", cnt_wr, 3);
        run("pull06", 1'b0, 1'b1, 8'h06, 0, 5, 9, 1'b0);
        chk_int("pull06_rd", cnt_rd, 2);
        chk_int("pull06_pul", cnt_pul, 2);
        run("pull10", 1'b0, 1'b1, 8'h10, 0, 5, 9, 1'b0);
        run("pull00", 1'b0, 1'b1, 8'h00, 0, 1, 1, 1'b0);
        chk_int("pull00_strobes", cnt_rd + cnt_wr + cnt_dec + cnt_pul, 0);
        run("both02", 1'b1, 1'b1, 8'h02, 0, 3, 3, 1'b1);
        chk_int("both02_dec", cnt_dec, 1);
        chk_int("both02_wr", cnt_wr, 1);
        chk_int("both02_rd", cnt_rd, 0);
        run("pushFF", 1'b1, 1'b0, 8'hFF, 0, 25, 25, 1'b0);
        run("pushFF_cen", 1'b1, 1'b0, 8'hFF, 1, 25, 25, 1'b0);
        chk_int("pushFF_cen_dec", cnt_dec, 12);
        run("pullFF", 1'b0, 1'b1, 8'hFF, 0, 25, 49, 1'b0);

        for (int r = 0; r < 30; r++) begin
            logic [7:0] rm;
            logic       rp;
            rm = 8'($urandom);
            rp = 1'($urandom);
            run("rand", rp, ~rp | 1'($urandom_range(0, 1)), rm, 2, -1, -1, 1'($urandom));
        end

        // abort in the middle of a push
        cen = 1'b1; start_psh = 1'b1; mask = 8'hFF;
        tick;
        start_psh = 1'b0;
        repeat (5) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk_frame("abort_rd0", act0, '0);
        chk_frame("abort_rd2", act2, '0);
        tick;
        tick;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
